// File: rtl/mycpu2_pkg.sv
// Shared encodings for mycpu2: opcodes, FSM states and the RETI sub-encoding.
package mycpu2_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_IN   = 4'hB,
    OP_OUT  = 4'hC,
    OP_BZ   = 4'hD,
    OP_JR   = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // NOP with this low-12-bit pattern is RETI when interrupts are compiled in
  localparam logic [11:0] RETI_ENC = 12'h001;

endpackage

// File: rtl/mycpu2_rf.sv
// mycpu2 register file: 16 x DW, two asynchronous read ports, one synchronous write port.
module mycpu2_rf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [3:0]    ra_a,
  input  logic [3:0]    ra_b,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b
);

  logic [15:0][DW-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs <= '0;
    else if (we) regs[wa] <= wd;
  end

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

endmodule

// File: rtl/mycpu2.sv
// mycpu2: multi-cycle CPU (FETCH/EXEC/MEM/HALT) on a req/rdy bus with unbounded wait states.
// Interrupt entry/RETI and the IE/EPC registers exist only when MYCPU2_IRQ_EN is defined.
module mycpu2
  import mycpu2_pkg::*;
#(
  parameter int          DW       = 16,
  parameter int          AW       = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned IRQ_VEC  = 'h0004
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] a_out,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  input  logic [DW-1:0] io_in,
  output logic          wen_out,
  output logic          iom_out,
  output logic          req_out,
  input  logic          rdy_in,
  input  logic          irq_in,
  output logic          halt_out
);

  state_t            state, state_nx;
  logic [AW-1:0]     pc, pc_nx;
  logic [15:0]       ir;
  logic              n_flag, z_flag;
  opcode_t           op;
  logic [DW-1:0]     ra_val, rb_val, alu, rf_wd;
  logic              rf_we, is_alu, flag_we;
  logic signed [7:0] imm_s;

  assign op       = opcode_t'(ir[15:12]);
  assign imm_s    = ir[7:0];
  assign is_alu   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  assign flag_we  = (state == S_EXEC) && is_alu;
  assign d_out    = rb_val;
  assign halt_out = (state == S_HALT);

  mycpu2_rf #(.DW(DW)) u_rf (
    .clk  (clk),
    .rst  (rst),
    .we   (rf_we),
    .wa   (ir[11:8]),
    .wd   (rf_wd),
    .ra_a (ir[7:4]),
    .ra_b (ir[3:0]),
    .rd_a (ra_val),
    .rd_b (rb_val)
  );

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = ra_val + rb_val;
      OP_SUB:  alu = ra_val - rb_val;
      OP_AND:  alu = ra_val & rb_val;
      OP_OR:   alu = ra_val | rb_val;
      OP_XOR:  alu = ra_val ^ rb_val;
      OP_SHL:  alu = ra_val << 1;
      OP_SHR:  alu = ra_val >> 1;
      default: alu = '0;
    endcase
  end

`ifdef MYCPU2_IRQ_EN
  logic          ie, is_reti, irq_take;
  logic [AW-1:0] epc, ret_pc;
  assign is_reti = (state == S_EXEC) && (op == OP_NOP) && (ir[11:0] == RETI_ENC);
`else
  logic [AW:0] unused_irq;
  assign unused_irq = {irq_in, AW'(IRQ_VEC)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    req_out  = 1'b0;
    wen_out  = 1'b0;
    iom_out  = 1'b0;
    a_out    = pc;
    rf_we    = 1'b0;
    rf_wd    = alu;
`ifdef MYCPU2_IRQ_EN
    irq_take = 1'b0;
    ret_pc   = pc;
`endif
    case (state)
      S_FETCH: begin
        req_out = 1'b1;
        if (rdy_in) begin
          state_nx = S_EXEC;
          pc_nx    = pc + AW'(1);
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (op)
          OP_LDI: begin
            rf_we = 1'b1;
            rf_wd = DW'(imm_s);
          end
          OP_LD, OP_ST, OP_IN, OP_OUT: state_nx = S_MEM;
          // pc already points past the BZ, so the offset is relative to pc_next
          OP_BZ:   if (z_flag) pc_nx = pc + AW'(imm_s);
          OP_JR:   pc_nx = ra_val[AW-1:0];
          OP_HALT: state_nx = S_HALT;
          default: rf_we = is_alu;
        endcase
`ifdef MYCPU2_IRQ_EN
        if (is_reti) pc_nx = epc;
`endif
      end
      S_MEM: begin
        req_out = 1'b1;
        a_out   = ra_val[AW-1:0];
        iom_out = (op == OP_IN) || (op == OP_OUT);
        wen_out = (op == OP_ST) || (op == OP_OUT);
        if (rdy_in) begin
          state_nx = S_FETCH;
          rf_we    = (op == OP_LD) || (op == OP_IN);
          rf_wd    = (op == OP_IN) ? io_in : d_in;
        end
      end
      default: ;
    endcase
`ifdef MYCPU2_IRQ_EN
    // taken only on the transition into FETCH (or from HALT), so MEM cycles defer it
    if (irq_in && ie && ((state != S_FETCH && state_nx == S_FETCH) || state == S_HALT)) begin
      irq_take = 1'b1;
      ret_pc   = pc_nx;
      pc_nx    = AW'(IRQ_VEC);
      state_nx = S_FETCH;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= AW'(RESET_PC);
      ir     <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (state == S_FETCH && rdy_in) ir <= d_in[15:0];
      if (flag_we) begin
        n_flag <= alu[DW-1];
        z_flag <= (alu == '0);
      end
    end
  end

`ifdef MYCPU2_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie  <= 1'b1;
      epc <= '0;
    end else if (irq_take) begin
      ie  <= 1'b0;
      epc <= ret_pc;
    end else if (is_reti) begin
      ie  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mycpu2.sv
// Scoreboard bench for mycpu2: expected bus transfers are queued per program and
// compared every cycle the DUT requests the bus (including wait-state cycles).
module tb_mycpu2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_out, d_in, d_out, io_in;
  logic        wen_out, iom_out, req_out, rdy_in, irq_in, halt_out;

  logic [15:0] mem [0:255];
  assign d_in = mem[a_out[7:0]];

  mycpu2 dut (
    .clk(clk), .rst(rst), .a_out(a_out), .d_in(d_in), .d_out(d_out),
    .io_in(io_in), .wen_out(wen_out), .iom_out(iom_out), .req_out(req_out),
    .rdy_in(rdy_in), .irq_in(irq_in), .halt_out(halt_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        io;
    int          gap;
  } xact_t;

  xact_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] irq_on_addr = 16'hFFFF;
  logic [15:0] irq_off_addr = 16'hFFFF;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h8, rd, imm};
  endfunction

  task automatic ef(input logic [15:0] a, input int g);
    sb.push_back('{addr: a, data: 16'h0, wr: 1'b0, io: 1'b0, gap: g});
  endtask

  task automatic er(input logic [15:0] a, input logic io, input int g);
    sb.push_back('{addr: a, data: 16'h0, wr: 1'b0, io: io, gap: g});
  endtask

  task automatic ew(input logic [15:0] a, input logic [15:0] d, input logic io, input int g);
    sb.push_back('{addr: a, data: d, wr: 1'b1, io: io, gap: g});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy_in = 1'b0; irq_in = 1'b0;
    irq_on_addr = 16'hFFFF; irq_off_addr = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Serves the bus with wait_n wait states per transfer and checks each request cycle
  task automatic run_program(input string name, input int wait_n, input int budget);
    int w, last, n;
    xact_t e;
    w = 0; last = cyc; n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (req_out) begin
        e = sb[0];
        checks++;
        if (a_out !== e.addr || wen_out !== e.wr || iom_out !== e.io || (e.wr && d_out !== e.data)) begin
          errors++;
          $display("FAIL %s bus: got a=%h d=%h wen=%b iom=%b, expected a=%h d=%h wen=%b iom=%b",
                   name, a_out, d_out, wen_out, iom_out, e.addr, e.data, e.wr, e.io);
        end
        if (w < wait_n) begin
          rdy_in = 1'b0;
          w++;
        end else begin
          rdy_in = 1'b1;
          w = 0;
          if (e.gap > 0) begin
            checks++;
            if (cyc - last !== e.gap) begin
              errors++;
              $display("FAIL %s latency at a=%h: got %0d cycles, expected %0d", name, e.addr, cyc - last, e.gap);
            end
          end
          last = cyc;
          if (e.wr && !e.io) mem[e.addr[7:0]] = e.data;
          if (!e.wr && !e.io && e.addr == irq_on_addr) irq_in = 1'b1;
          if (!e.wr && !e.io && e.addr == irq_off_addr) irq_in = 1'b0;
          void'(sb.pop_front());
        end
      end else begin
        rdy_in = 1'b0;
      end
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d transfers outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    rdy_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy_in = 1'b0; irq_in = 1'b0;
    @(negedge clk);
    checks++;
    if (halt_out !== 1'b0 || wen_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got halt=%b wen=%b, expected 0 0", halt_out, wen_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || a_out !== 16'h0000 || wen_out !== 1'b0 || iom_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: got req=%b a=%h wen=%b iom=%b, expected 1 0000 0 0", req_out, a_out, wen_out, iom_out);
    end
    // reset during a stalled store must abort it
    clear_mem();
    mem[0] = ldi(4'd1, 8'h10); mem[1] = ldi(4'd2, 8'h33); mem[2] = ins(4'hA, 4'd0, 4'd1, 4'd2);
    mem[16] = 16'h0BAD;
    do_reset();
    ef(16'd0, 0); ef(16'd1, 2); ef(16'd2, 2);
    run_program("reset_mid", 0, 20);
    @(negedge clk);
    checks++;
    if (req_out !== 1'b1 || wen_out !== 1'b1 || a_out !== 16'h0010 || d_out !== 16'h0033) begin
      errors++;
      $display("FAIL reset_mid_store: got req=%b wen=%b a=%h d=%h, expected 1 1 0010 0033", req_out, wen_out, a_out, d_out);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[16] !== 16'h0BAD || a_out !== 16'h0000 || req_out !== 1'b1 || wen_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got mem=%h a=%h req=%b wen=%b, expected 0bad 0000 1 0", mem[16], a_out, req_out, wen_out);
    end
  endtask

  task automatic test_alu();
    logic [15:0] vals [7];
    vals = '{16'h0002, 16'h0008, 16'h0005, 16'hFFFD, 16'hFFF8, 16'hFFFA, 16'h7FFE};
    clear_mem();
    mem[0] = ldi(4'd1, 8'h05);
    mem[1] = ldi(4'd2, 8'hFD);
    mem[2] = ins(4'h1, 4'd3, 4'd1, 4'd2);
    mem[3] = ins(4'h2, 4'd4, 4'd1, 4'd2);
    mem[4] = ins(4'h3, 4'd5, 4'd1, 4'd2);
    mem[5] = ins(4'h4, 4'd6, 4'd1, 4'd2);
    mem[6] = ins(4'h5, 4'd7, 4'd1, 4'd2);
    mem[7] = ins(4'h7, 4'd9, 4'd2, 4'd0);
    mem[8] = ins(4'h6, 4'd8, 4'd2, 4'd0);
    for (int r = 0; r < 7; r++) mem[9+r] = ins(4'hC, 4'd0, 4'd0, 4'(r + 3));
    do_reset();
    ef(16'd0, 0);
    for (int a = 1; a < 10; a++) ef(16'(a), 2);
    for (int k = 0; k < 7; k++) begin
      ew(16'h0000, vals[k], 1'b1, 2);
      ef(16'(10 + k), 1);
    end
    run_program("alu", 0, 200);
    repeat (2) @(negedge clk);
    checks++;
    if (dut.n_flag !== 1'b1 || dut.z_flag !== 1'b0 || halt_out !== 1'b1) begin
      errors++;
      $display("FAIL alu_flags: got n=%b z=%b halt=%b, expected 1 0 1", dut.n_flag, dut.z_flag, halt_out);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0]  = ldi(4'd1, 8'h07);
    mem[1]  = ins(4'h2, 4'd4, 4'd1, 4'd1);
    mem[2]  = {4'hD, 4'h0, 8'h02};
    mem[3]  = ldi(4'd5, 8'h01);
    mem[4]  = ldi(4'd5, 8'h02);
    mem[5]  = ins(4'hC, 4'd0, 4'd0, 4'd4);
    mem[6]  = ins(4'h1, 4'd7, 4'd1, 4'd1);
    mem[7]  = {4'hD, 4'h0, 8'h05};
    mem[8]  = ldi(4'd8, 8'd12);
    mem[9]  = ins(4'hE, 4'd0, 4'd8, 4'd0);
    mem[12] = ins(4'h5, 4'd9, 4'd1, 4'd1);
    mem[13] = {4'hD, 4'h0, 8'h03};
    mem[17] = ins(4'hC, 4'd0, 4'd0, 4'd7);
    mem[18] = {4'hD, 4'h0, 8'hF8};
    do_reset();
    ef(16'd0, 0); ef(16'd1, 2); ef(16'd2, 2); ef(16'd5, 2);
    ew(16'h0000, 16'h0000, 1'b1, 2);
    ef(16'd6, 1); ef(16'd7, 2); ef(16'd8, 2); ef(16'd9, 2);
    ef(16'd12, 2); ef(16'd13, 2); ef(16'd17, 2);
    ew(16'h0000, 16'h000E, 1'b1, 2);
    ef(16'd18, 1); ef(16'd11, 2);
    run_program("branch", 0, 200);
  endtask

  task automatic test_mem_wait();
    clear_mem();
    mem[0] = ldi(4'd1, 8'h10);
    mem[1] = ldi(4'd5, 8'h20);
    mem[2] = ins(4'h9, 4'd2, 4'd5, 4'd0);
    mem[3] = ins(4'hA, 4'd0, 4'd1, 4'd2);
    mem[4] = ins(4'h9, 4'd6, 4'd1, 4'd0);
    mem[5] = ins(4'hC, 4'd0, 4'd0, 4'd6);
    mem[32] = 16'hABCD;
    mem[16] = 16'h0000;
    do_reset();
    ef(16'd0, 0); ef(16'd1, 0); ef(16'd2, 0);
    er(16'h0020, 1'b0, 0);
    ef(16'd3, 0);
    ew(16'h0010, 16'hABCD, 1'b0, 0);
    ef(16'd4, 0);
    er(16'h0010, 1'b0, 0);
    ef(16'd5, 0);
    ew(16'h0000, 16'hABCD, 1'b1, 0);
    ef(16'd6, 0);
    run_program("mem_wait", 3, 300);
    checks++;
    if (mem[16] !== 16'hABCD) begin
      errors++;
      $display("FAIL mem_store: got mem[10]=%h, expected abcd", mem[16]);
    end
  endtask

  task automatic test_io();
    clear_mem();
    io_in = 16'h1234;
    mem[0] = ldi(4'd1, 8'h07);
    mem[1] = ldi(4'd2, 8'h5A);
    mem[2] = ins(4'hC, 4'd0, 4'd1, 4'd2);
    mem[3] = ins(4'hB, 4'd3, 4'd1, 4'd0);
    mem[4] = ldi(4'd0, 8'h09);
    mem[5] = ins(4'hC, 4'd0, 4'd0, 4'd3);
    do_reset();
    ef(16'd0, 0); ef(16'd1, 2); ef(16'd2, 2);
    ew(16'h0007, 16'h005A, 1'b1, 2);
    ef(16'd3, 1);
    er(16'h0007, 1'b1, 2);
    ef(16'd4, 1); ef(16'd5, 2);
    ew(16'h0009, 16'h1234, 1'b1, 2);
    ef(16'd6, 1);
    run_program("io", 0, 100);
  endtask

  task automatic test_halt();
    int bad;
    clear_mem();
    mem[0] = ldi(4'd1, 8'h01);
    do_reset();
    ef(16'd0, 0); ef(16'd1, 2);
    run_program("halt", 0, 20);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      rdy_in = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (halt_out !== 1'b1 || req_out !== 1'b0 || wen_out !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL halt_hold: got halt=%b req=%b wen=%b, expected 1 0 0", halt_out, req_out, wen_out);
      end
    end
    rdy_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (halt_out !== 1'b0 || req_out !== 1'b1 || a_out !== 16'h0000) begin
      errors++;
      $display("FAIL halt_restart: got halt=%b req=%b a=%h, expected 0 1 0000", halt_out, req_out, a_out);
    end
  endtask

`ifdef MYCPU2_IRQ_EN
  task automatic test_irq();
    clear_mem();
    mem[0] = ldi(4'd1, 8'h01);
    mem[1] = ins(4'h1, 4'd2, 4'd1, 4'd1);
    mem[2] = ldi(4'd3, 8'h03);
    mem[4] = ins(4'hC, 4'd0, 4'd0, 4'd1);
    mem[5] = 16'h0001;
    do_reset();
    irq_on_addr = 16'd1;
    irq_off_addr = 16'd5;
    ef(16'd0, 0); ef(16'd1, 2); ef(16'd4, 2);
    ew(16'h0000, 16'h0001, 1'b1, 2);
    ef(16'd5, 1); ef(16'd2, 2); ef(16'd3, 2);
    run_program("irq", 0, 100);
    checks++;
    if (dut.epc !== 16'd2 || dut.ie !== 1'b1) begin
      errors++;
      $display("FAIL irq_state: got epc=%h ie=%b, expected 0002 1", dut.epc, dut.ie);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; rdy_in = 1'b0; irq_in = 1'b0; io_in = 16'h0000;
    clear_mem();
    test_reset();
    test_alu();
    test_branch();
    test_mem_wait();
    test_io();
    test_halt();
`ifdef MYCPU2_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
